// File: rtl/rst_seq_ctrl.sv
// Ordered reset sequencer: holds all domains in reset, then releases them one
// at a time in index order with an active-low ack handshake per stage.
module rst_seq_ctrl #(
  parameter int unsigned NUM_STAGES         = 3,
  parameter int unsigned MIN_ASSERT_CYCLES  = 16,
  parameter int unsigned ACK_TIMEOUT_CYCLES = 1024,
  parameter int unsigned TIMEOUT_MODE       = 1,
  parameter logic [NUM_STAGES-1:0] ACK_MASK = '0,
  localparam int unsigned SW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rst_req,
  input  logic [NUM_STAGES-1:0] ack_n,
  output logic [NUM_STAGES-1:0] rst_n,
  output logic                  seq_done,
  output logic [NUM_STAGES-1:0] timeout_err,
  output logic [1:0]            seq_state,
  output logic [SW-1:0]         seq_stage
);

  localparam int unsigned AW = $clog2((MIN_ASSERT_CYCLES > 2) ? MIN_ASSERT_CYCLES : 2);
  localparam int unsigned TW = $clog2((ACK_TIMEOUT_CYCLES > 2) ? ACK_TIMEOUT_CYCLES : 2);
  localparam logic [AW-1:0] ASSERT_LAST = AW'(MIN_ASSERT_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST =
    TW'((ACK_TIMEOUT_CYCLES > 0) ? ACK_TIMEOUT_CYCLES - 1 : 0);
  localparam logic [SW-1:0] STAGE_LAST = SW'(NUM_STAGES - 1);

  typedef enum logic [1:0] {
    S_ASSERT = 2'd0,
    S_ACK    = 2'd1,
    S_REL    = 2'd2,
    S_RUN    = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [SW-1:0]           stage_q, stage_d;
  logic [AW-1:0]           assert_cnt_q, assert_cnt_d;
  logic [TW-1:0]           wait_cnt_q, wait_cnt_d;
  logic [NUM_STAGES-1:0]   rst_n_q, rst_n_d;
  logic                    done_q, done_d;
  logic [NUM_STAGES-1:0]   err_q, err_d;

  logic ack_ok, to_hit, proceed;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_ASSERT;
      stage_q      <= '0;
      assert_cnt_q <= '0;
      wait_cnt_q   <= '0;
      rst_n_q      <= '0;
      done_q       <= 1'b0;
      err_q        <= '0;
    end else begin
      state_q      <= state_d;
      stage_q      <= stage_d;
      assert_cnt_q <= assert_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      rst_n_q      <= rst_n_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    stage_d      = stage_q;
    assert_cnt_d = assert_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    rst_n_d      = rst_n_q;
    done_d       = done_q;
    err_d        = err_q;

    // Acquire wait wants ack_n low; release wait wants it high again.
    ack_ok  = ACK_MASK[stage_q] |
              ((state_q == S_ACK) ? ~ack_n[stage_q] : ack_n[stage_q]);
    to_hit  = (ACK_TIMEOUT_CYCLES != 0) && !ack_ok && (wait_cnt_q == TO_LAST);
    proceed = ack_ok | (to_hit && (TIMEOUT_MODE == 1));

    if (rst_req) begin
      state_d      = S_ASSERT;
      stage_d      = '0;
      assert_cnt_d = '0;
      wait_cnt_d   = '0;
      rst_n_d      = '0;
      done_d       = 1'b0;
    end else begin
      case (state_q)
        S_ASSERT: begin
          rst_n_d = '0;
          if (assert_cnt_q == ASSERT_LAST) begin
            state_d    = S_ACK;
            stage_d    = '0;
            wait_cnt_d = '0;
          end else begin
            assert_cnt_d = assert_cnt_q + AW'(1);
          end
        end
        S_ACK, S_REL: begin
          if (to_hit) err_d[stage_q] = 1'b1;
          if (proceed) begin
            wait_cnt_d = '0;
            if (state_q == S_ACK) begin
              rst_n_d[stage_q] = 1'b1;
              state_d          = S_REL;
            end else if (stage_q == STAGE_LAST) begin
              state_d = S_RUN;
              done_d  = 1'b1;
            end else begin
              stage_d = stage_q + SW'(1);
              state_d = S_ACK;
            end
          end else if (!to_hit && (ACK_TIMEOUT_CYCLES != 0)) begin
            wait_cnt_d = wait_cnt_q + TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign rst_n       = rst_n_q;
  assign seq_done    = done_q;
  assign timeout_err = err_q;
  assign seq_state   = state_q;
  assign seq_stage   = stage_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Bench for rst_seq_ctrl: three configurations run side by side against a
// behavioural sequencer model, plus directed timing checks and random traffic.
module tb_rst_seq_ctrl;

  logic clk = 1'b0;
  logic reset, rst_req;
  logic [2:0] ack [3];
  logic [2:0] rn  [3];
  logic       dn  [3];
  logic [2:0] er  [3];
  logic [1:0] st  [3];
  logic [1:0] sg  [3];

  logic [2:0] d1 [3];
  logic [2:0] d2 [3];
  logic [2:0] stuck [3];
  bit         rnd [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // A: mode 1, no mask.  B: mode 0 (wait forever).  C: mode 1, mask 101.
  rst_seq_ctrl #(.NUM_STAGES(3), .MIN_ASSERT_CYCLES(4), .ACK_TIMEOUT_CYCLES(16),
                 .TIMEOUT_MODE(1), .ACK_MASK(3'b000)) u_a (
    .clk(clk), .reset(reset), .rst_req(rst_req), .ack_n(ack[0]), .rst_n(rn[0]),
    .seq_done(dn[0]), .timeout_err(er[0]), .seq_state(st[0]), .seq_stage(sg[0]));
  rst_seq_ctrl #(.NUM_STAGES(3), .MIN_ASSERT_CYCLES(4), .ACK_TIMEOUT_CYCLES(16),
                 .TIMEOUT_MODE(0), .ACK_MASK(3'b000)) u_b (
    .clk(clk), .reset(reset), .rst_req(rst_req), .ack_n(ack[1]), .rst_n(rn[1]),
    .seq_done(dn[1]), .timeout_err(er[1]), .seq_state(st[1]), .seq_stage(sg[1]));
  rst_seq_ctrl #(.NUM_STAGES(3), .MIN_ASSERT_CYCLES(4), .ACK_TIMEOUT_CYCLES(16),
                 .TIMEOUT_MODE(1), .ACK_MASK(3'b101)) u_c (
    .clk(clk), .reset(reset), .rst_req(rst_req), .ack_n(ack[2]), .rst_n(rn[2]),
    .seq_done(dn[2]), .timeout_err(er[2]), .seq_state(st[2]), .seq_stage(sg[2]));

  // Behavioural model: ph 0 hold, 1 waiting for ack low, 2 waiting for ack high, 3 running.
  typedef struct {
    int         ph;
    int         held;
    int         stage;
    int         waited;
    logic [2:0] rstn;
    logic       done;
    logic [2:0] err;
  } mdl_t;

  mdl_t m [3];

  function automatic mdl_t fresh(input logic [2:0] err);
    mdl_t r;
    r.ph = 0; r.held = 0; r.stage = 0; r.waited = 0;
    r.rstn = 3'b000; r.done = 1'b0; r.err = err;
    return r;
  endfunction

  function automatic mdl_t step(input mdl_t cur, input logic req, input logic [2:0] a,
                                input int mode, input logic [2:0] mask);
    mdl_t r = cur;
    bit ok, tmo;
    if (req) return fresh(cur.err);
    if (r.ph == 0) begin
      if (r.held == 3) begin r.ph = 1; r.stage = 0; r.waited = 0; end
      else r.held++;
    end else if (r.ph == 1 || r.ph == 2) begin
      ok  = mask[r.stage] || (a[r.stage] == ((r.ph == 1) ? 1'b0 : 1'b1));
      tmo = !ok && (r.waited == 15);
      if (tmo) r.err[r.stage] = 1'b1;
      if (ok || (tmo && mode == 1)) begin
        r.waited = 0;
        if (r.ph == 1) begin r.rstn[r.stage] = 1'b1; r.ph = 2; end
        else if (r.stage == 2) begin r.ph = 3; r.done = 1'b1; end
        else begin r.stage++; r.ph = 1; end
      end else if (!tmo) begin
        r.waited++;
      end
    end
    return r;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) m[i] <= fresh(3'b000);
    end else begin
      m[0] <= step(m[0], rst_req, ack[0], 1, 3'b000);
      m[1] <= step(m[1], rst_req, ack[1], 0, 3'b000);
      m[2] <= step(m[2], rst_req, ack[2], 1, 3'b101);
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if ({rn[i], dn[i], er[i], st[i], sg[i]} !==
            {m[i].rstn, m[i].done, m[i].err, 2'(m[i].ph), 2'(m[i].stage)}) begin
          errors++;
          $display("FAIL model_cmp[%0d] t=%0t: got rst_n=%b done=%b err=%b state=%0d stage=%0d, want rst_n=%b done=%b err=%b state=%0d stage=%0d",
                   i, $time, rn[i], dn[i], er[i], st[i], sg[i],
                   m[i].rstn, m[i].done, m[i].err, m[i].ph, m[i].stage);
        end
      end
    end
  end

  // Ack source: each domain's rst_n delayed two cycles, or random, with stuck-high overrides.
  initial begin
    for (int i = 0; i < 3; i++) begin ack[i] = '0; d1[i] = '0; d2[i] = '0; end
    forever begin
      @(posedge clk);
      #2;
      for (int i = 0; i < 3; i++) begin
        ack[i] = (rnd[i] ? 3'($urandom) : d2[i]) | stuck[i];
        d2[i]  = d1[i];
        d1[i]  = rn[i];
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    int k;
    reset = 1'b1; rst_req = 1'b0;
    for (int i = 0; i < 3; i++) begin stuck[i] = '0; rnd[i] = 1'b0; end
    stuck[1] = 3'b010;  // B: stage 1 ack never arrives
    stuck[2] = 3'b111;  // C: acks tied high
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset_state", {rn[0], dn[0], er[0], st[0], rn[1], rn[2]}, 0);

    // Sequence from reset release
    tick(4);  chk("a_e4_rst_n", rn[0], 3'b000);
    tick(1);  chk("a_e5_rst_n", rn[0], 3'b001); chk("c_e5_rst_n", rn[2], 3'b001);
    tick(3);  chk("a_e8_rst_n", rn[0], 3'b001);
    tick(1);  chk("a_e9_rst_n", rn[0], 3'b011);
    tick(4);  chk("a_e13_rst_n", rn[0], 3'b111);
    tick(2);  chk("a_e15_done", dn[0], 1'b0);
    tick(1);  chk("a_e16_done", dn[0], 1'b1); chk("a_e16_err", er[0], 3'b000);
              chk("a_e16_state", st[0], 2'd3);
    tick(5);  chk("c_e21_rst_n", rn[2], 3'b001);
    tick(1);  chk("c_e22_rst_n", rn[2], 3'b011); chk("c_e22_err", er[2], 3'b010);
    tick(1);  chk("b_e23_err", er[1], 3'b000); chk("b_e23_rst_n", rn[1], 3'b001);
    tick(1);  chk("b_e24_err", er[1], 3'b010); chk("c_e24_rst_n", rn[2], 3'b111);
    tick(1);  chk("c_e25_done", dn[2], 1'b1); chk("c_e25_err", er[2], 3'b010);

    for (int unsigned i = 0; i < 100; i++) begin
      tick(1);
      chk("b_hold", {rn[1], st[1], sg[1], dn[1]}, {3'b001, 2'd1, 2'd1, 1'b0});
    end
    stuck[1] = '0;
    k = 0;
    while (!dn[1] && k < 40) begin tick(1); k++; end
    chk("b_resume_done", {dn[1], rn[1]}, {1'b1, 3'b111});

    // Long request hold, then release
    rst_req = 1'b1;
    for (int unsigned i = 0; i < 10; i++) begin
      tick(1);
      chk("req_hold_rst_n", {rn[0], rn[1], rn[2], dn[0]}, 0);
    end
    rst_req = 1'b0;
    tick(4);  chk("req_e4_rst_n", rn[0], 3'b000);
    tick(1);  chk("req_e5_rst_n", rn[0], 3'b001);
    tick(30); chk("req_all_done", {dn[0], dn[1], dn[2]}, 3'b111);

    // A: stage 1 ack stuck, recover by timeout
    stuck[0] = 3'b010;
    rst_req = 1'b1; tick(1); rst_req = 1'b0;
    tick(23); chk("a_to_e23", {rn[0], er[0]}, {3'b001, 3'b000});
    tick(1);  chk("a_to_e24", {rn[0], er[0]}, {3'b011, 3'b010});
    tick(16); chk("a_to_done", {dn[0], rn[0]}, {1'b1, 3'b111});
    stuck[0] = '0;

    // A: restart while stage 2 is in its release wait
    rst_req = 1'b1; tick(1); rst_req = 1'b0;
    tick(14); chk("a_mid_rel", {rn[0], dn[0], st[0], sg[0]}, {3'b111, 1'b0, 2'd2, 2'd2});
    rst_req = 1'b1; tick(1); rst_req = 1'b0;
    chk("a_mid_abort", {rn[0], dn[0], st[0]}, {3'b000, 1'b0, 2'd0});
    tick(5);  chk("a_re_e5", rn[0], 3'b001);
    tick(4);  chk("a_re_e9", rn[0], 3'b011);
    tick(4);  chk("a_re_e13", rn[0], 3'b111);
    tick(3);  chk("a_re_e16", {dn[0], er[0]}, {1'b1, 3'b010});

    // Random traffic, model-checked every cycle
    for (int unsigned blk = 0; blk < 75; blk++) begin
      for (int i = 0; i < 3; i++) begin
        rnd[i]   = bit'($urandom_range(0, 1));
        stuck[i] = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
      end
      for (int unsigned c = 0; c < 40; c++) begin
        rst_req = ($urandom_range(0, 99) == 0);
        tick(1);
      end
    end
    rst_req = 1'b0;
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rst_seq_ctrl.md
Name: rst_seq_ctrl

Overview:
Parametrised, ordered reset sequencer for N downstream reset domains in the FIM.
- Holds every domain in reset while a reset request is active, plus a minimum assertion time.
- Releases domains one at a time in index order (0 first). For each domain it waits for an active-low acknowledge, in the style of the PCIe cold/warm ack handshake, before releasing it, then waits for release confirmation before moving on.
- Adds per-stage ack masking, ack timeouts with selectable recovery mode, and a sequence-done flag.
- Sits between the resynchronised system reset sources and per-domain output resync chains.

Parameters:
NUM_STAGES, 3, number of reset domains sequenced (1..16)
MIN_ASSERT_CYCLES, 16, minimum cycles all rst_n held low after rst_req deasserts (>=1)
ACK_TIMEOUT_CYCLES, 1024, cycles allowed per ack wait; 0 disables timeout
TIMEOUT_MODE, 1, 0 = keep waiting after timeout (flag only); 1 = proceed as if ack received
ACK_MASK, '0, NUM_STAGES bits; bit i = 1: stage i has no ack, both waits skipped

Ports:
clk  input  1  sequencer clock
reset  input  1  asynchronous, active-high reset
rst_req  input  1  reset request, synchronous to clk (caller resyncs); 1 = hold/restart sequence
ack_n  input  NUM_STAGES  per-domain ack, active low, synchronous to clk; 0 = domain in reset
rst_n  output  NUM_STAGES  per-domain reset, active low, registered
seq_done  output  1  1 = all domains released, sequence complete
timeout_err  output  NUM_STAGES  sticky per-stage ack timeout flag
seq_state  output  2  debug: 0 ASSERT, 1 STG_ACK, 2 STG_REL, 3 RUN
seq_stage  output  $clog2(NUM_STAGES) (min 1)  debug: current stage index

Behaviour:
- Reset (async, reset=1):
  - rst_n all 0, seq_done 0, timeout_err 0.
  - State ASSERT, stage 0, counters 0.
- All outputs are registered; changes appear the edge after the qualifying condition.
- ASSERT:
  - All rst_n are 0.
  - assert_cnt clears while rst_req=1 and increments each cycle while rst_req=0.
  - When rst_req=0 and assert_cnt==MIN_ASSERT_CYCLES-1: go to STG_ACK with stage=0.
- STG_ACK (stage i, rst_n[i]=0):
  - Proceeds when ack_n[i]==0, or ACK_MASK[i]=1, or a timeout occurs with TIMEOUT_MODE=1.
  - On proceeding: next edge sets rst_n[i]=1 and goes to STG_REL.
- STG_REL (stage i, rst_n[i]=1):
  - Proceeds when ack_n[i]==1, or ACK_MASK[i]=1, or a timeout occurs with TIMEOUT_MODE=1.
  - On proceeding: if i==NUM_STAGES-1, go to RUN and set seq_done=1; else i+1 and go to STG_ACK.
- RUN:
  - All rst_n are 1 and seq_done is 1; hold until rst_req.
- Timeout:
  - wait_cnt clears on every entry to STG_ACK/STG_REL.
  - If ACK_TIMEOUT_CYCLES>0 and wait_cnt reaches ACK_TIMEOUT_CYCLES-1 without the ack, timeout_err[i] is set (sticky until reset).
  - TIMEOUT_MODE=0: the counter saturates and the FSM keeps waiting.
- rst_req=1 in any state, including mid-sequence: next edge drives all rst_n=0 and seq_done=0, goes to ASSERT, clears assert_cnt, stage=0. rst_req takes priority over any simultaneous ack or timeout.
- Released stages never re-assert except via rst_req or reset. Stage j>i is never released before stage i completes STG_REL.
- Minimum latency:
  - Fully masked stage: 2 cycles.
  - rst_req fall to seq_done: MIN_ASSERT_CYCLES + 2*NUM_STAGES cycles when acks are already satisfied.
- Counter widths are $clog2(max(param,2)); there is no wrap, since counters stop at their terminal values.

Test Plan:
1. N=3, MIN=4, TIMEOUT=16, MODE=1, MASK=0; ack model ack_n=rst_n delayed 2 cycles; rst_req=0 from reset release → rst_n[0] rises 5 edges after release, rst_n[1] 4 edges later, rst_n[2] 4 after that; seq_done=1 at edge 16; timeout_err=000.
2. Same configuration, hold rst_req=1 for 10 cycles after reset → all rst_n stay 0 throughout; rst_n[0] rises exactly 5 edges after rst_req falls.
3. Same configuration, ack_n[1] stuck at 1 → stage 1 waits 16 cycles, timeout_err=010, rst_n[1] rises on the next edge, sequence completes with seq_done=1.
4. MODE=0, ack_n[1] stuck at 1 → timeout_err[1]=1; rst_n=001 held indefinitely (checked for 100 cycles); seq_state=1, seq_stage=1; releasing ack_n[1] to 0 resumes the sequence.
5. Assert rst_req for 1 cycle while in STG_REL of stage 2 (rst_n=111) → next edge rst_n=000, seq_done=0, state ASSERT; full resequence repeats the timing of scenario 1, and timeout_err is unchanged.
6. MASK=3'b101, ack_n tied to 1 → stages 0 and 2 take 2 cycles each, stage 1 follows ack timing; no timeout on masked stages; final rst_n=111, seq_done=1.
